// File: rtl/code_mem_arbiter.sv
// code_mem_arbiter: shares one code RAM port between core fetch and a host loader.
// Core owns the port by default; the loader borrows it through req/grant.
module code_mem_arbiter #(
    parameter int IPR_WIDTH = 16,
    parameter int MAX_HOLD  = 16,
    parameter int MIN_CORE  = 4
) (
    input  logic                 sysclk,
    input  logic                 sysreset,
    input  logic [IPR_WIDTH-1:0] core_addr,
    output logic [15:0]          core_data,
    output logic                 core_ready,
    input  logic                 ldr_req,
    output logic                 ldr_grant,
    input  logic                 ldr_valid,
    input  logic                 ldr_we,
    input  logic [IPR_WIDTH-1:0] ldr_addr,
    input  logic [15:0]          ldr_wdata,
    output logic                 ldr_ack,
    output logic [15:0]          ldr_rdata,
    output logic                 ldr_err,
    output logic [IPR_WIDTH-1:0] mem_addr,
    output logic                 mem_we,
    output logic [15:0]          mem_wdata,
    input  logic [15:0]          mem_rdata
);

    typedef enum logic [1:0] {
        CORE,
        DRAIN,
        LOADER,
        RELEASE
    } state_t;

    localparam logic [7:0] GAP_MAX   = 8'(MIN_CORE);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [7:0] gap_cnt;
    logic [7:0] gap_nxt;
    logic [7:0] hold_cnt;
    logic       rd_pend;
    logic       accept;

    assign ldr_grant = (state == LOADER);
    assign accept    = ldr_valid & ldr_grant;

    // The current CORE cycle counts toward the gap, so the loader
    // is re-granted after exactly MIN_CORE core cycles.
    assign gap_nxt = (gap_cnt >= GAP_MAX) ? GAP_MAX : gap_cnt + 8'd1;

    assign core_data = mem_rdata;
    assign ldr_rdata = rd_pend ? mem_rdata : 16'h0000;
    assign mem_addr  = ldr_grant ? ldr_addr : core_addr;
    assign mem_we    = accept & ldr_we & ~sysreset;
    assign mem_wdata = ldr_grant ? ldr_wdata : 16'h0000;

    // Ownership FSM, gap/hold counters and registered handshake outputs.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state      <= CORE;
            gap_cnt    <= GAP_MAX;
            hold_cnt   <= 8'd0;
            core_ready <= 1'b0;
            ldr_ack    <= 1'b0;
            ldr_err    <= 1'b0;
            rd_pend    <= 1'b0;
        end else begin
            core_ready <= (state == CORE);
            ldr_ack    <= accept;
            rd_pend    <= accept & ~ldr_we;
            ldr_err    <= ldr_valid & ~ldr_grant;
            unique case (state)
                CORE: begin
                    gap_cnt <= gap_nxt;
                    if (ldr_req && gap_nxt >= GAP_MAX) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    hold_cnt <= 8'd0;
                    state    <= LOADER;
                end
                LOADER: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (!ldr_req || hold_cnt == HOLD_LAST) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    gap_cnt <= 8'd0;
                    state   <= CORE;
                end
                default: state <= CORE;
            endcase
        end
    end

endmodule
